// File: rtl/mc_control_if.sv
// Control-path bundle between the multicycle MIPS controller and its datapath/memory.
// The controller drives the mux selects and enables; the datapath returns IR fields and flags.
interface mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       sov;
    logic       mem_ready;
    logic [5:0] alu_func;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       ovf;
    logic       err;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, sov, mem_ready,
        output alu_func, alu_src_a, alu_src_b, ext_zero, pc_src, pc_en, i_or_d,
               mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
               instr_done, ovf, err, state
    );

    modport slave (
        output opcode, funct, zero, sov, mem_ready,
        input  alu_func, alu_src_a, alu_src_b, ext_zero, pc_src, pc_en, i_or_d,
               mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
               instr_done, ovf, err, state
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: Moore decode of the state register drives the datapath,
// memory accesses stall on mem_ready, and trapping add/sub/addi writes are suppressed on overflow.
module mc_control #(
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_control_if.master  bus
);
    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] MEM_ADDR  = 4'd2;
    localparam logic [3:0] MEM_READ  = 4'd3;
    localparam logic [3:0] MEM_WB    = 4'd4;
    localparam logic [3:0] MEM_WRITE = 4'd5;
    localparam logic [3:0] R_EXEC    = 4'd6;
    localparam logic [3:0] R_WB      = 4'd7;
    localparam logic [3:0] BRANCH    = 4'd8;
    localparam logic [3:0] JUMP      = 4'd9;
    localparam logic [3:0] I_EXEC    = 4'd10;
    localparam logic [3:0] I_WB      = 4'd11;
    localparam logic [3:0] JR        = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;

    localparam logic [5:0] ALU_ADD = 6'h20;
    localparam logic [5:0] ALU_SUB = 6'h22;
    localparam logic [5:0] ALU_AND = 6'h24;
    localparam logic [5:0] ALU_OR  = 6'h25;
    localparam logic [5:0] ALU_XOR = 6'h26;
    localparam logic [5:0] ALU_SLT = 6'h2A;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       ovf_q;
    logic       err_q;
    logic       funct_ok;
    logic       illegal;

    always_comb begin
        funct_ok = 1'b0;
        case (bus.funct)
            6'h00, 6'h02, 6'h03, 6'h20, 6'h22,
            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: funct_ok = 1'b1;
            default:                          funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            FETCH:     if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (bus.funct == F_JR) state_d = JR;
                        else if (funct_ok)     state_d = R_EXEC;
                        else begin
                            state_d = FETCH;
                            illegal = 1'b1;
                        end
                    end
                    OP_LW, OP_SW:   state_d = MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_J:           state_d = JUMP;
                    OP_ADDI, OP_ADDIU, OP_SLTI,
                    OP_ANDI, OP_ORI, OP_XORI: state_d = I_EXEC;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (bus.mem_ready) state_d = MEM_WB;
            MEM_WRITE: if (bus.mem_ready) state_d = FETCH;
            R_EXEC:    state_d = R_WB;
            I_EXEC:    state_d = I_WB;
            default:   state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == R_EXEC || state_q == I_EXEC) ovf_q <= bus.sov;
            if (illegal && ILLEGAL_TRAP != 0) err_q <= 1'b1;
        end
    end

    always_comb begin
        bus.alu_func   = '0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.ext_zero   = 1'b0;
        bus.pc_src     = 2'd0;
        bus.pc_en      = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.instr_done = 1'b0;
        bus.ovf        = 1'b0;
        case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.alu_func  = ALU_ADD;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_b  = 2'd3;
                bus.alu_func   = ALU_ADD;
                bus.instr_done = illegal;
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_func  = ALU_ADD;
            end
            MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            MEM_WRITE: begin
                bus.mem_write  = 1'b1;
                bus.i_or_d     = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_func  = bus.funct;
            end
            R_WB: begin
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
                bus.ovf        = ovf_q && (bus.funct == F_ADD || bus.funct == F_SUB);
                bus.reg_write  = !bus.ovf;
            end
            BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_func   = ALU_SUB;
                bus.pc_src     = 2'd1;
                bus.pc_en      = (bus.opcode == OP_BNE) ? !bus.zero : bus.zero;
                bus.instr_done = 1'b1;
            end
            JUMP: begin
                bus.pc_src     = 2'd2;
                bus.pc_en      = 1'b1;
                bus.instr_done = 1'b1;
            end
            I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                case (bus.opcode)
                    OP_SLTI: bus.alu_func = ALU_SLT;
                    OP_ANDI: bus.alu_func = ALU_AND;
                    OP_ORI:  bus.alu_func = ALU_OR;
                    OP_XORI: bus.alu_func = ALU_XOR;
                    default: bus.alu_func = ALU_ADD;
                endcase
                bus.ext_zero = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI) ||
                               (bus.opcode == OP_XORI);
            end
            I_WB: begin
                bus.instr_done = 1'b1;
                bus.ovf        = ovf_q && (bus.opcode == OP_ADDI);
                bus.reg_write  = !bus.ovf;
            end
            JR: begin
                bus.pc_src     = 2'd3;
                bus.pc_en      = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset holds every enable low while still presenting the FETCH mux values.
        if (!rst_n) begin
            bus.pc_en      = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.mem_write  = 1'b0;
            bus.instr_done = 1'b0;
            bus.ovf        = 1'b0;
        end
    end

    assign bus.err   = err_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_mc_control.sv
// Directed-vector bench for mc_control: steps instructions cycle by cycle with hand-derived
// expected control values, sampling 3 time units after each rising edge.
module tb_mc_control;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mc_control_if bus ();

    mc_control #(.ILLEGAL_TRAP(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_fetch();
        bus.mem_ready = 1'b1;
        settle();
        check("fetch_state", 32'(bus.state), 32'd0);
        check("fetch_ir_write", 32'(bus.ir_write), 32'd1);
        check("fetch_pc_en", 32'(bus.pc_en), 32'd1);
        tick();
    endtask

    // mem_ready is raised in DECODE to show it is ignored outside memory states
    task automatic do_decode(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] nxt);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.mem_ready = 1'b1;
        settle();
        check("decode_state", 32'(bus.state), 32'd1);
        check("decode_alu_src_b", 32'(bus.alu_src_b), 32'd3);
        tick();
        bus.mem_ready = 1'b0;
        settle();
        check("after_decode_state", 32'(bus.state), 32'(nxt));
    endtask

    task automatic branch(input string tag, input logic [5:0] op, input logic z, input logic exp_en);
        do_fetch();
        do_decode(op, 6'h00, 4'd8);
        bus.zero = z;
        settle();
        check({tag, "_pc_en"}, 32'(bus.pc_en), 32'(exp_en));
        check({tag, "_pc_src"}, 32'(bus.pc_src), 32'd1);
        check({tag, "_alu_func"}, 32'(bus.alu_func), 32'h22);
        check({tag, "_done"}, 32'(bus.instr_done), 32'd1);
        tick();
        bus.zero = 1'b0;
        settle();
        check({tag, "_back_fetch"}, 32'(bus.state), 32'd0);
    endtask

    task automatic ovf_case(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic [3:0] exec_st, input logic sov_exec,
                            input logic exp_wr, input logic exp_ovf);
        do_fetch();
        do_decode(op, fn, exec_st);
        bus.sov = sov_exec;
        tick();
        bus.sov = ~sov_exec;
        settle();
        check({tag, "_wb_state"}, 32'(bus.state), 32'(exec_st + 4'd1));
        check({tag, "_reg_write"}, 32'(bus.reg_write), 32'(exp_wr));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        check({tag, "_done"}, 32'(bus.instr_done), 32'd1);
        tick();
        bus.sov = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h20;
        bus.zero      = 1'b0;
        bus.sov       = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset mid-R_EXEC, then idle fetch with 3 wait cycles
        do_fetch();
        do_decode(6'h00, 6'h20, 4'd6);
        rst_n = 1'b0;
        settle();
        check("rst_async_state", 32'(bus.state), 32'd0);
        check("rst_mem_read", 32'(bus.mem_read), 32'd1);
        check("rst_alu_src_b", 32'(bus.alu_src_b), 32'd1);
        bus.mem_ready = 1'b1;
        settle();
        check("rst_pc_en_forced", 32'(bus.pc_en), 32'd0);
        check("rst_ir_write_forced", 32'(bus.ir_write), 32'd0);
        tick();
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("idle_state", 32'(bus.state), 32'd0);
            check("idle_mem_read", 32'(bus.mem_read), 32'd1);
            check("idle_pc_en", 32'(bus.pc_en), 32'd0);
            check("idle_ir_write", 32'(bus.ir_write), 32'd0);
            tick();
        end
        bus.opcode = 6'h02;
        do_fetch();
        check("decode_after_idle", 32'(bus.state), 32'd1);
        check("ir_write_one_cycle", 32'(bus.ir_write), 32'd0);
        tick();
        settle();
        check("j_state", 32'(bus.state), 32'd9);
        check("j_pc_src", 32'(bus.pc_src), 32'd2);
        check("j_pc_en", 32'(bus.pc_en), 32'd1);
        tick();

        // lw with 2 wait states: 0,1,2,3,3,3,4
        do_fetch();
        do_decode(6'h23, 6'h00, 4'd2);
        check("lw_addr_src_b", 32'(bus.alu_src_b), 32'd2);
        check("lw_addr_src_a", 32'(bus.alu_src_a), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = (i == 2);
            settle();
            check("lw_read_state", 32'(bus.state), 32'd3);
            check("lw_read_req", 32'(bus.mem_read), 32'd1);
            check("lw_read_i_or_d", 32'(bus.i_or_d), 32'd1);
            tick();
        end
        bus.mem_ready = 1'b0;
        settle();
        check("lw_wb_state", 32'(bus.state), 32'd4);
        check("lw_wb_reg_write", 32'(bus.reg_write), 32'd1);
        check("lw_wb_mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
        check("lw_wb_done", 32'(bus.instr_done), 32'd1);
        tick();

        // sw with 1 wait state
        do_fetch();
        do_decode(6'h2B, 6'h00, 4'd2);
        tick();
        settle();
        check("sw_state", 32'(bus.state), 32'd5);
        check("sw_mem_write", 32'(bus.mem_write), 32'd1);
        check("sw_done_wait", 32'(bus.instr_done), 32'd0);
        tick();
        bus.mem_ready = 1'b1;
        settle();
        check("sw_state_hold", 32'(bus.state), 32'd5);
        check("sw_done", 32'(bus.instr_done), 32'd1);
        tick();

        branch("beq_taken", 6'h04, 1'b1, 1'b1);
        branch("beq_not", 6'h04, 1'b0, 1'b0);
        branch("bne_taken", 6'h05, 1'b0, 1'b1);
        branch("bne_not", 6'h05, 1'b1, 1'b0);

        ovf_case("add_ovf", 6'h00, 6'h20, 4'd6, 1'b1, 1'b0, 1'b1);
        ovf_case("sub_ok", 6'h00, 6'h22, 4'd6, 1'b0, 1'b1, 1'b0);
        ovf_case("and_sov", 6'h00, 6'h24, 4'd6, 1'b1, 1'b1, 1'b0);
        ovf_case("addiu_sov", 6'h09, 6'h00, 4'd10, 1'b1, 1'b1, 1'b0);
        ovf_case("addi_ovf", 6'h08, 6'h00, 4'd10, 1'b1, 1'b0, 1'b1);
        ovf_case("addi_ok", 6'h08, 6'h00, 4'd10, 1'b0, 1'b1, 1'b0);

        // ALU function selection
        do_fetch();
        do_decode(6'h0C, 6'h00, 4'd10);
        check("andi_func", 32'(bus.alu_func), 32'h24);
        check("andi_ext_zero", 32'(bus.ext_zero), 32'd1);
        tick();
        tick();
        do_fetch();
        do_decode(6'h0A, 6'h00, 4'd10);
        check("slti_func", 32'(bus.alu_func), 32'h2A);
        check("slti_ext_zero", 32'(bus.ext_zero), 32'd0);
        tick();
        tick();
        do_fetch();
        do_decode(6'h00, 6'h03, 4'd6);
        check("sra_func", 32'(bus.alu_func), 32'h03);
        tick();
        tick();

        // Illegal opcode: 2-cycle instruction, sticky err
        do_fetch();
        bus.opcode = 6'h3F;
        settle();
        check("ill_done", 32'(bus.instr_done), 32'd1);
        check("ill_reg_write", 32'(bus.reg_write), 32'd0);
        check("ill_pc_en", 32'(bus.pc_en), 32'd0);
        check("ill_err_before", 32'(bus.err), 32'd0);
        tick();
        settle();
        check("ill_back_fetch", 32'(bus.state), 32'd0);
        check("ill_err_set", 32'(bus.err), 32'd1);

        // jr, err must stay set
        do_fetch();
        do_decode(6'h00, 6'h08, 4'd12);
        check("jr_pc_src", 32'(bus.pc_src), 32'd3);
        check("jr_pc_en", 32'(bus.pc_en), 32'd1);
        check("jr_err_sticky", 32'(bus.err), 32'd1);
        tick();

        rst_n = 1'b0;
        settle();
        check("err_cleared", 32'(bus.err), 32'd0);
        tick();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_control.md
# mc_control

Multicycle MIPS main control FSM. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath muxes and write enables. It generates the 6-bit `alu_func` consumed by the ALU. It consumes the ALU's `zero` and `sov` flags for branch resolution and overflow suppression. Memory accesses use a ready handshake, so variable-latency memory stalls the FSM in place.

## Interface

Parameters:
- `ILLEGAL_TRAP`, default 1: when 1, an unsupported opcode or funct sets the sticky `err` output. When 0, it is silently treated as a NOP.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; stable from the cycle after FETCH completes.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag (combinational, same cycle).
- `sov`  in  1  ALU signed-overflow flag.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `alu_func`  out  6  ALU function: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x2A slt, or IR funct pass-through.
- `alu_src_a`  out  1  0 = PC, 1 = reg A.
- `alu_src_b`  out  2  0 = reg B, 1 = constant 4, 2 = extended imm, 3 = extended imm<<2.
- `ext_zero`  out  1  1 = zero-extend the immediate (andi/ori/xori), 0 = sign-extend.
- `pc_src`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = reg A (jr).
- `pc_en`  out  1  PC write enable; branch condition already resolved.
- `i_or_d`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  IR load enable.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction.
- `ovf`  out  1  one-cycle pulse when a trapping add/sub/addi write is suppressed.
- `err`  out  1  sticky illegal-instruction flag; cleared only by reset.
- `state`  out  4  current state encoding, for debug.

## Operation

State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, JR=12. Outputs are a Moore decode of `state`, plus `opcode`/`funct` for ALU selection. Every output not named for a state is 0 in that state.

- **FETCH:** `mem_read=1`, `i_or_d=0`, `alu_src_a=0`, `alu_src_b=1`, `alu_func=0x20`, `pc_src=0`.
  - `ir_write` and `pc_en` equal `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE:** `alu_src_b=3`, `alu_func=0x20` (branch target into ALUOut). Next state by opcode:
  - 0x00 with funct 0x08 → JR.
  - 0x00 with another supported funct (0x00, 0x02, 0x03, 0x20, 0x22, 0x24–0x27, 0x2A) → R_EXEC.
  - 0x23 and 0x2B → MEM_ADDR.
  - 0x04 and 0x05 → BRANCH.
  - 0x02 → JUMP.
  - 0x08, 0x09, 0x0A, 0x0C, 0x0D, 0x0E → I_EXEC.
  - Anything else → FETCH with `instr_done=1`; `err` is set if `ILLEGAL_TRAP`.
- **MEM_ADDR:** `alu_src_a=1`, `alu_src_b=2`, `alu_func=0x20`. Goes to MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ:** `mem_read=1`, `i_or_d=1`. Waits for `mem_ready`, then goes to MEM_WB.
- **MEM_WB:** `reg_write=1`, `mem_to_reg=1`, `reg_dst=0`, `instr_done=1`. Goes to FETCH.
- **MEM_WRITE:** `mem_write=1`, `i_or_d=1`. Waits for `mem_ready`; on that cycle `instr_done=1` and the FSM goes to FETCH.
- **R_EXEC:** `alu_src_a=1`, `alu_src_b=0`, `alu_func=funct`. `sov` is registered into `ovf_q`. Goes to R_WB.
- **R_WB:** `reg_dst=1`, `instr_done=1`, `reg_write = !(ovf_q && funct∈{0x20,0x22})`, and `ovf` equals the suppression condition. Goes to FETCH.
- **BRANCH:** `alu_src_a=1`, `alu_src_b=0`, `alu_func=0x22`, `pc_src=1`.
  - `pc_en = zero` for beq, `!zero` for bne.
  - `instr_done=1`; goes to FETCH.
- **JUMP:** `pc_src=2`, `pc_en=1`, `instr_done=1`. Goes to FETCH.
- **JR:** `pc_src=3`, `pc_en=1`, `instr_done=1`. Goes to FETCH.
- **I_EXEC:** `alu_src_a=1`, `alu_src_b=2`. `sov` is registered into `ovf_q`.
  - `alu_func`: 0x20 for addi/addiu, 0x2A for slti, 0x24/0x25/0x26 for andi/ori/xori.
  - `ext_zero=1` for andi/ori/xori only.
  - Goes to I_WB.
- **I_WB:** `reg_dst=0`, `instr_done=1`, `reg_write = !(ovf_q && opcode==0x08)`, `ovf` as in R_WB. Goes to FETCH. addiu never traps.

## Timing

- **Reset:** `rst_n` low forces `state=FETCH`, `ovf_q=0` and `err=0` immediately (asynchronously). While `rst_n` is low:
  - `pc_en`, `ir_write`, `reg_write`, `mem_write`, `instr_done` and `ovf` are forced to 0.
  - `mem_read=1` and the other FETCH mux values are still driven.
- **Reset mid-instruction:** abandons the instruction with no write. The first fetch starts on the first rising edge after release.
- **Cycles per instruction with zero wait states:** lw 5, sw 4, R-type 4, I-type 4, beq/bne 3, j/jr 3, illegal 2.
  - Each cycle `mem_ready` is low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- **Handshake:** a request is held constant until `mem_ready`. `mem_ready` outside FETCH, MEM_READ and MEM_WRITE is ignored.
- **Branch resolution:** `zero` is sampled combinationally in BRANCH only.
- **Overflow:** the relevant `sov` is the EXEC-cycle value only.

## Test plan

- **Reset and idle fetch:** assert `rst_n=0` mid-R_EXEC, then release with `mem_ready=0` for 3 cycles. Expect `state=0` throughout, `mem_read=1`, `pc_en=0`, `ir_write=0`. On the 4th cycle `mem_ready=1` gives `pc_en=1` and `ir_write=1` for exactly one cycle.
- **lw with 2 wait states:** opcode 0x23, `mem_ready` low for 2 cycles in MEM_READ. Expect 7 cycles total, `state` sequence 0,1,2,3,3,3,4, and `reg_write=1` with `mem_to_reg=1` in the last cycle.
- **Branches:** beq (0x04) with `zero=1` gives `pc_en=1` and `pc_src=1` in BRANCH. beq with `zero=0` gives `pc_en=0`. bne (0x05) with `zero=0` gives `pc_en=1`. All take 3 cycles.
- **R-type add overflow:** funct 0x20 with `sov=1` in R_EXEC gives `reg_write=0` and `ovf=1` in R_WB. The same sequence with addiu (0x09) gives `reg_write=1` and `ovf=0`.
- **ALU function selection:** andi (0x0C) gives `alu_func=0x24` and `ext_zero=1` in I_EXEC. slti (0x0A) gives `alu_func=0x2A` and `ext_zero=0`. R-type sra (funct 0x03) gives `alu_func=0x03`.
- **Illegal opcode 0x3F:** expect a 2-cycle instruction with `instr_done=1` in DECODE and `err=1` from then until reset. No `reg_write`, `mem_write` or `pc_en` outside FETCH. jr (funct 0x08) gives `pc_src=3` and `pc_en=1` in state 12.
